// File: rtl/pc_unit.sv
// Fetch program counter with boot bubble, halt/resume, trap/mret redirect.
// Optional compressed-instruction support via `PC_UNIT_RVC_EN.
module pc_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect,
  input  logic [XLEN-1:0]  PC_in,
  input  logic             trap_req,
  input  logic [XLEN-1:0]  trap_vector,
  input  logic             mret,
  input  logic [XLEN-1:0]  epc,
  input  logic             halt_req,
  input  logic             resume,
  input  logic             is_compressed,
  output logic [XLEN-1:0]  PC_out,
  output logic [XLEN-1:0]  PC_next_seq,
  output logic             fetch_valid,
  output logic             halted,
  output logic             misaligned,
  output logic [XLEN-1:0]  bad_addr,
  output logic [CNT_W-1:0] redirect_count
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t          state;
  logic [XLEN-1:0] step;
  logic [XLEN-1:0] trap_tgt;
  logic [CNT_W-1:0] cnt_inc;
  logic            mis_epc;
  logic            mis_pc_in;
  logic            unused_in;

`ifdef PC_UNIT_RVC_EN
  assign step      = is_compressed ? XLEN'(2) : XLEN'(4);
  assign mis_epc   = epc[0];
  assign mis_pc_in = PC_in[0];
`else
  assign step      = XLEN'(4);
  assign mis_epc   = |epc[1:0];
  assign mis_pc_in = |PC_in[1:0];
`endif

  assign unused_in   = ^{is_compressed, trap_vector[1:0]};
  assign PC_next_seq = PC_out + step;
  assign trap_tgt    = {trap_vector[XLEN-1:2], 2'b00};
  // Saturate rather than wrap so a stuck count is visibly "many".
  assign cnt_inc     = (&redirect_count) ? redirect_count
                     : redirect_count + CNT_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= BOOT;
      PC_out         <= RESET_VECTOR;
      fetch_valid    <= 1'b0;
      halted         <= 1'b0;
      misaligned     <= 1'b0;
      bad_addr       <= '0;
      redirect_count <= '0;
    end else begin
      misaligned <= 1'b0;
      unique case (state)
        BOOT: begin
          state       <= RUN;
          fetch_valid <= 1'b1;
        end
        RUN: begin
          if (trap_req) begin
            PC_out         <= trap_tgt;
            redirect_count <= cnt_inc;
          end else if (mret) begin
            if (mis_epc) begin
              misaligned <= 1'b1;
              bad_addr   <= epc;
            end else begin
              PC_out         <= epc;
              redirect_count <= cnt_inc;
            end
          end else if (redirect) begin
            if (mis_pc_in) begin
              misaligned <= 1'b1;
              bad_addr   <= PC_in;
            end else begin
              PC_out         <= PC_in;
              redirect_count <= cnt_inc;
            end
          end else if (halt_req) begin
            state       <= HALT;
            fetch_valid <= 1'b0;
            halted      <= 1'b1;
          end else if (!stall) begin
            PC_out <= PC_next_seq;
          end
        end
        HALT: begin
          if (trap_req) begin
            PC_out         <= trap_tgt;
            redirect_count <= cnt_inc;
            state          <= RUN;
            fetch_valid    <= 1'b1;
            halted         <= 1'b0;
          end else if (resume) begin
            state       <= RUN;
            fetch_valid <= 1'b1;
            halted      <= 1'b0;
          end
        end
        default: begin
          state       <= BOOT;
          fetch_valid <= 1'b0;
          halted      <= 1'b0;
        end
      endcase
    end
  end

endmodule
